// File: rtl/fmadd_mantissa_adder_pipe.sv
// Two-stage valid/ready mantissa add/subtract for the FMADD datapath.
// S1 orders and conditions the operands; S2 adds and fixes up a mispredicted operand order.
module fmadd_mantissa_adder_pipe #(
  parameter  int MAN   = 22,
  parameter  int TAG_W = 4,
  localparam int W     = 2*MAN+4
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_mant_a,
  input  logic [W-1:0]     in_mant_b,
  input  logic             in_eff_sub,
  input  logic             in_a_gt_b,
  input  logic             in_sticky,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_mant,
  output logic             out_carry,
  output logic             out_flip,
  output logic             out_zero,
  output logic             out_sticky,
  output logic [TAG_W-1:0] out_tag
);

  logic             v1, v2;
  logic [W-1:0]     s1_large, s1_inv;
  logic             s1_cin, s1_sub, s1_sticky;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_adv, s1_move, in_fire;
  logic [W-1:0]     large_sel, small_sel;
  logic [W:0]       sum;
  logic [W-1:0]     res_mant;
  logic             res_carry, res_flip;

  assign s2_adv    = ~v2 | out_ready;
  assign in_ready  = ~v1 | s2_adv;
  assign in_fire   = in_valid & in_ready;
  assign s1_move   = v1 & s2_adv;
  assign out_valid = v2;

  assign large_sel = in_a_gt_b ? in_mant_a : in_mant_b;
  assign small_sel = in_a_gt_b ? in_mant_b : in_mant_a;

  // Whenever in_ready is high S1 is either empty or draining, so it simply takes in_valid.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      v1 <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
    end else if (in_ready) begin
      v1 <= in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_large  <= '0;
      s1_inv    <= '0;
      s1_cin    <= 1'b0;
      s1_sub    <= 1'b0;
      s1_sticky <= 1'b0;
      s1_tag    <= '0;
    end else if (in_fire && !flush) begin
      s1_large  <= large_sel;
      s1_inv    <= in_eff_sub ? ~small_sel : small_sel;
      s1_cin    <= in_eff_sub & ~in_sticky;
      s1_sub    <= in_eff_sub;
      s1_sticky <= in_sticky;
      s1_tag    <= in_tag;
    end
  end

  // No carry out of a subtraction means large < small: negate the result back to a magnitude.
  always_comb begin
    sum       = {1'b0, s1_large} + {1'b0, s1_inv} + {{W{1'b0}}, s1_cin};
    res_mant  = sum[W-1:0];
    res_carry = 1'b0;
    res_flip  = 1'b0;
    if (!s1_sub) begin
      res_carry = sum[W];
    end else if (!sum[W]) begin
      res_mant = ~sum[W-1:0] + {{(W-1){1'b0}}, s1_cin};
      res_flip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      v2 <= 1'b0;
    end else if (flush) begin
      v2 <= 1'b0;
    end else if (s2_adv) begin
      v2 <= v1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_mant   <= '0;
      out_carry  <= 1'b0;
      out_flip   <= 1'b0;
      out_zero   <= 1'b0;
      out_sticky <= 1'b0;
      out_tag    <= '0;
    end else if (s1_move && !flush) begin
      out_mant   <= res_mant;
      out_carry  <= res_carry;
      out_flip   <= res_flip;
      out_zero   <= (res_mant == '0);
      out_sticky <= s1_sticky;
      out_tag    <= s1_tag;
    end
  end

endmodule

// File: doc/fmadd_mantissa_adder_pipe.md
# fmadd_mantissa_adder_pipe

Pipelined, parametrised mantissa add/subtract unit for the FMADD datapath. It sits between the exponent-align stage and the normaliser. It takes two aligned mantissas and produces a magnitude result plus carry, sign-flip, zero and sticky flags. Unlike the combinational mantissa adder it replaces, it has a two-stage valid/ready pipeline with backpressure, a synchronous flush, a pass-through tag, and correct handling of a mispredicted operand order.

## Interface
- MAN, 22, mantissa field width; datapath width W = 2*MAN+4 (48 at default).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

- clk  in  1  clock, all state on rising edge.
- rst_l  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; drops all in-flight operations.
- in_valid  in  1  input operation present.
- in_ready  out  1  unit accepts input this cycle.
- in_mant_a  in  W  aligned mantissa A.
- in_mant_b  in  W  aligned mantissa B.
- in_eff_sub  in  1  1 = effective subtraction, 0 = addition.
- in_a_gt_b  in  1  predicted |A| > |B| (from the exponent compare).
- in_sticky  in  1  bits were shifted out of the smaller operand.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_mant  out  W  result magnitude.
- out_carry  out  1  carry out of an addition.
- out_flip  out  1  subtraction result was negative; the sign must be inverted.
- out_zero  out  1  out_mant == 0.
- out_sticky  out  1  registered copy of in_sticky.
- out_tag  out  TAG_W  tag of this result.

## Operation
- The pipeline has two stages, S1 and S2. Each stage has one valid bit and a payload register.
- A transfer happens on a cycle where valid and ready are both 1. S1 loads on an input transfer.
- S1 captures:
  - large = in_a_gt_b ? A : B, and small = the other operand.
  - inv = in_eff_sub ? ~small : small.
  - cin = in_eff_sub & ~in_sticky. With sticky set, the unit uses the ones' complement, matching the truncated-LSB convention.
  - eff_sub, sticky, tag.
- S2 computes the (W+1)-bit sum = {0,large} + {0,inv} + cin, and registers:
  - Addition: out_mant = sum[W-1:0], out_carry = sum[W], out_flip = 0.
  - Subtraction with sum[W] = 1: out_mant = sum[W-1:0], out_carry = 0, out_flip = 0.
  - Subtraction with sum[W] = 0: the prediction was wrong. out_mant = ~sum[W-1:0] + cin, out_carry = 0, out_flip = 1.
  - out_zero = (out_mant == 0). out_sticky and out_tag pass through from S1.
- All arithmetic is modulo 2^W, except the carry bit described above.
- Flush clears both valid bits on the next edge. An input offered in the same cycle as flush is dropped.

## Timing
- Reset values: all valid bits 0, and every output 0 (out_mant, out_carry, out_flip, out_zero, out_sticky, out_tag). in_ready is 1 out of reset.
- Latency is 2 cycles. An input accepted at edge N appears at out_valid after edge N+1, when there is no stall.
- Throughput is 1 operation per cycle while out_ready = 1.
- s2_adv = ~v2 | out_ready. in_ready = ~v1 | s2_adv. in_ready is combinational and does not depend on in_valid.
- S2 loads from S1 when v1 & s2_adv. v2 clears when out_ready and nothing moves in from S1.
- While out_valid = 1 and out_ready = 0, every out_* signal holds stable.
- With both stages full and out_ready = 0, in_ready = 0 and no input is accepted.
- Simultaneous accept-into-S1 and S1-to-S2 move: both happen on the same edge, with no bubble.
- If reset is asserted mid-operation, all state clears immediately (asynchronously). No result from before reset ever appears.
- Flush has priority over every transfer in that cycle.

## Test plan
(MAN = 22, W = 48, values in hex.)
- **Add:** A=0x800000000000, B=0x800000000000, eff_sub=0, a_gt_b=1 -> 2 cycles later out_mant=0, out_carry=1, out_zero=1, out_flip=0.
- **Subtract, correct order:** A=0x30, B=0x10, eff_sub=1, a_gt_b=1, sticky=0 -> out_mant=0x20, out_flip=0, out_carry=0. Sticky=1 with the same operands -> out_mant=0x1F, out_sticky=1.
- **Mispredicted order:** A=0x10, B=0x30, eff_sub=1, a_gt_b=1 -> out_mant=0x20, out_flip=1. Equal operands A=B=0x55 -> out_mant=0, out_zero=1, out_flip=0.
- **Backpressure:** stream tags 1..5 back-to-back and hold out_ready=0 for 4 cycles. in_ready must fall after 2 accepts and outputs must stay stable. Then release; all 5 tags must emerge in order with no loss or duplication.
- **Flush and reset:** with 2 operations in flight, pulse flush -> out_valid=0 next cycle and neither result appears. Repeat with rst_l low mid-stream -> all outputs are 0 immediately and in_ready=1 after release.
- **Random:** random operands, modes and out_ready against a reference model computing |large - small|, flip and carry -> bit-exact match with in-order tags.
